// File: rtl/alu_driver.sv
// Drives one ALU transaction at a time: accepts a command, presents it to the ALU,
// collects the result (or times out) and hands it downstream with running counters.
module alu_driver #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  input  logic [SEL_WIDTH-1:0]    cmd_sel,
  input  logic                    cmd_bad_par,
  output logic                    alu_valid,
  output logic [DATA_WIDTH-1:0]   alu_data_1,
  output logic [DATA_WIDTH-1:0]   alu_data_2,
  output logic [SEL_WIDTH-1:0]    alu_sel,
  output logic                    alu_parity,
  input  logic                    alu_ack,
  input  logic                    alu_rvalid,
  input  logic [2*DATA_WIDTH-1:0] alu_rdata,
  input  logic                    alu_err,
  output logic                    alu_rready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*DATA_WIDTH-1:0] res_data,
  output logic                    res_err,
  output logic                    res_timeout,
  output logic [15:0]             txn_cnt,
  output logic [15:0]             err_cnt
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_DELIVER  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_phase_cnt;
  logic                    w_expire;
  logic                    w_accept;
  logic                    w_rsp;
  logic                    w_timeout;
  logic                    w_done;

  logic                    r_cmd_ready;
  logic                    r_alu_valid;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [SEL_WIDTH-1:0]    r_sel;
  logic                    r_parity;
  logic                    r_res_valid;
  logic [2*DATA_WIDTH-1:0] r_res_data;
  logic                    r_res_err;
  logic                    r_res_timeout;
  logic [15:0]             r_txn_cnt;
  logic [15:0]             r_err_cnt;

  function automatic logic par_calc(input logic [2*DATA_WIDTH+SEL_WIDTH-1:0] v, input logic inv);
    return (^v) ^ inv;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rsp       = 1'b0;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    w_expire    = (r_phase_cnt == CW'(TIMEOUT - 1));
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      // A handshake landing on the expiry cycle wins over the timeout.
      ST_SEND: begin
        if (alu_ack) begin
          w_state_nxt = ST_WAIT_RES;
        end else if (w_expire) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DELIVER;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_WAIT_RES: begin
        if (alu_rvalid) begin
          w_rsp       = 1'b1;
          w_state_nxt = ST_DELIVER;
        end else if (w_expire) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DELIVER;
        end else begin
          w_state_nxt = ST_WAIT_RES;
        end
      end
      ST_DELIVER: begin
        if (res_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DELIVER;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Restarts on every state change so each handshake phase gets a full budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase_cnt <= '0;
    end else if (r_state != w_state_nxt) begin
      r_phase_cnt <= '0;
    end else if (!w_expire) begin
      r_phase_cnt <= r_phase_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_ready   <= 1'b1;
      r_alu_valid   <= 1'b0;
      r_res_valid   <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_sel         <= '0;
      r_parity      <= 1'b0;
      r_res_data    <= '0;
      r_res_err     <= 1'b0;
      r_res_timeout <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_alu_valid <= (w_state_nxt == ST_SEND);
      r_res_valid <= (w_state_nxt == ST_DELIVER);
      if (w_accept) begin
        r_a      <= cmd_a;
        r_b      <= cmd_b;
        r_sel    <= cmd_sel;
        r_parity <= par_calc({cmd_a, cmd_b, cmd_sel}, cmd_bad_par);
      end
      if (w_rsp) begin
        r_res_data    <= alu_rdata;
        r_res_err     <= alu_err;
        r_res_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_res_data    <= '0;
        r_res_err     <= 1'b0;
        r_res_timeout <= 1'b1;
      end else if (w_done) begin
        r_res_data    <= '0;
        r_res_err     <= 1'b0;
        r_res_timeout <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txn_cnt <= 16'd0;
      r_err_cnt <= 16'd0;
    end else if (w_done) begin
      r_txn_cnt <= r_txn_cnt + 16'd1;
      if ((r_res_err || r_res_timeout) && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign alu_valid   = r_alu_valid;
  assign alu_data_1  = r_a;
  assign alu_data_2  = r_b;
  assign alu_sel     = r_sel;
  assign alu_parity  = r_parity;
  // Result acknowledge is the capture cycle itself, so it can never linger.
  assign alu_rready  = (r_state == ST_WAIT_RES) && alu_rvalid;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_err     = r_res_err;
  assign res_timeout = r_res_timeout;
  assign txn_cnt     = r_txn_cnt;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver; the ALU side is driven by hand from the stimulus.
module tb_alu_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [2:0]  cmd_sel;
  logic        cmd_bad_par;
  logic        alu_valid;
  logic [15:0] alu_data_1;
  logic [15:0] alu_data_2;
  logic [2:0]  alu_sel;
  logic        alu_parity;
  logic        alu_ack;
  logic        alu_rvalid;
  logic [31:0] alu_rdata;
  logic        alu_err;
  logic        alu_rready;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic        res_timeout;
  logic [15:0] txn_cnt;
  logic [15:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  alu_driver #(.DATA_WIDTH(16), .SEL_WIDTH(3), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_bad_par(cmd_bad_par),
    .alu_valid(alu_valid), .alu_data_1(alu_data_1), .alu_data_2(alu_data_2),
    .alu_sel(alu_sel), .alu_parity(alu_parity),
    .alu_ack(alu_ack), .alu_rvalid(alu_rvalid), .alu_rdata(alu_rdata),
    .alu_err(alu_err), .alu_rready(alu_rready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .res_timeout(res_timeout),
    .txn_cnt(txn_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel, input logic bad);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_bad_par = bad;
    tick();
    cmd_valid = 1'b0; cmd_bad_par = 1'b0;
  endtask

  task automatic ack_send();
    alu_ack = 1'b1;
    tick();
    alu_ack = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic err);
    alu_rvalid = 1'b1; alu_rdata = data; alu_err = err;
    #1;
    check_val("rready_pulse", alu_rready, 1'b1);
    tick();
    alu_rvalid = 1'b0; alu_rdata = 32'd0; alu_err = 1'b0;
  endtask

  task automatic accept_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; cmd_valid = 1'b0; cmd_a = 16'd0; cmd_b = 16'd0; cmd_sel = 3'd0;
    cmd_bad_par = 1'b0; alu_ack = 1'b0; alu_rvalid = 1'b0; alu_rdata = 32'd0;
    alu_err = 1'b0; res_ready = 1'b0;
    tick(); tick();
    check_val("rst_cmd_ready", cmd_ready, 1'b1);
    check_val("rst_alu_valid", alu_valid, 1'b0);
    check_val("rst_res_valid", res_valid, 1'b0);
    check_val("rst_txn_cnt", txn_cnt, 16'd0);
    check_val("rst_err_cnt", err_cnt, 16'd0);
    rst = 1'b1;
    tick();

    // Stray ack while idle must not start anything.
    alu_ack = 1'b1; tick(); alu_ack = 1'b0;
    check_val("idle_ack_ignored", {cmd_ready, alu_valid}, 2'b10);

    // Basic add, then hold downstream off for 10 cycles.
    issue(16'h0003, 16'h0005, 3'd0, 1'b0);
    check_val("t1_alu_valid", alu_valid, 1'b1);
    check_val("t1_cmd_ready", cmd_ready, 1'b0);
    check_val("t1_data", {alu_data_1, alu_data_2, alu_sel}, {16'h0003, 16'h0005, 3'd0});
    check_val("t1_parity", alu_parity, 1'b0);
    ack_send();
    check_val("t1_valid_drop", alu_valid, 1'b0);
    check_val("t1_rready_idle", alu_rready, 1'b0);
    tick();
    respond(32'h0000_0008, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check_val("t1_hold_valid", res_valid, 1'b1);
      check_val("t1_hold_data", {res_data, res_err, res_timeout}, {32'h0000_0008, 1'b0, 1'b0});
      check_val("t1_hold_cmd_ready", cmd_ready, 1'b0);
      check_val("t1_hold_rready", alu_rready, 1'b0);
      tick();
    end
    accept_res();
    check_val("t1_res_valid_off", res_valid, 1'b0);
    check_val("t1_txn_cnt", txn_cnt, 16'd1);
    check_val("t1_err_cnt", err_cnt, 16'd0);
    check_val("t1_cmd_ready", cmd_ready, 1'b1);

    // Forced bad parity, ALU reports error.
    issue(16'h0001, 16'h0000, 3'd0, 1'b1);
    check_val("t2_parity", alu_parity, 1'b0);
    ack_send();
    respond(32'h0000_0001, 1'b1);
    check_val("t2_res_err", res_err, 1'b1);
    accept_res();
    check_val("t2_cnts", {txn_cnt, err_cnt}, {16'd2, 16'd1});

    // No ack: timeout in SEND; rvalid driven throughout must be ignored.
    alu_rvalid = 1'b1; alu_rdata = 32'h0000_DEAD;
    issue(16'h00F0, 16'h000F, 3'd2, 1'b0);
    n = 0;
    while (alu_valid && n < 200) begin
      n++;
      tick();
    end
    check_val("t3_valid_cycles", n, 64);
    check_val("t3_res", {res_valid, res_timeout, res_err, res_data}, {1'b1, 1'b1, 1'b0, 32'd0});
    check_val("t3_rready", alu_rready, 1'b0);
    alu_rvalid = 1'b0; alu_rdata = 32'd0;
    accept_res();
    check_val("t3_cnts", {txn_cnt, err_cnt}, {16'd3, 16'd2});

    // Reset while waiting for the result.
    issue(16'h0010, 16'h0020, 3'd1, 1'b0);
    ack_send();
    rst = 1'b0;
    #1;
    check_val("t4_rst_outs", {cmd_ready, alu_valid, res_valid, alu_rready}, 4'b1000);
    check_val("t4_rst_cnts", {txn_cnt, err_cnt}, 32'd0);
    check_val("t4_rst_data", {alu_data_1, alu_parity}, 17'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    issue(16'h1234, 16'h0001, 3'd4, 1'b0);
    check_val("t4_parity", alu_parity, 1'b1);
    ack_send();
    respond(32'h0000_1235, 1'b0);
    check_val("t4_res_data", res_data, 32'h0000_1235);
    accept_res();
    check_val("t4_cnts", {txn_cnt, err_cnt}, {16'd1, 16'd0});

    // Result arrives in the very cycle the wait budget expires.
    issue(16'h0002, 16'h0002, 3'd3, 1'b0);
    ack_send();
    for (int i = 0; i < 63; i++) tick();
    check_val("t5_not_yet", res_valid, 1'b0);
    respond(32'hCAFE_BABE, 1'b0);
    check_val("t5_res", {res_valid, res_timeout, res_data}, {1'b1, 1'b0, 32'hCAFE_BABE});
    accept_res();
    check_val("t5_cnts", {txn_cnt, err_cnt}, {16'd2, 16'd0});

    // No result: timeout in WAIT_RES.
    issue(16'h0007, 16'h0001, 3'd5, 1'b0);
    ack_send();
    n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    check_val("t6_wait_cycles", n, 64);
    check_val("t6_res", {res_timeout, res_err, res_data}, {1'b1, 1'b0, 32'd0});
    accept_res();
    check_val("t6_cnts", {txn_cnt, err_cnt}, {16'd3, 16'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand width.
REQ-002 SHALL have parameter SEL_WIDTH, default 3, opcode width.
REQ-003 SHALL have parameter TIMEOUT, default 64, max cycles waited per handshake phase (>=2).
REQ-004 SHALL have ports:
- clk  in  1  clock; one clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_a, cmd_b  in  DATA_WIDTH each  operands
- cmd_sel  in  SEL_WIDTH  opcode
- cmd_bad_par  in  1  inject parity error (invert parity)
- alu_valid  out  1  to ALU valid_ip
- alu_data_1, alu_data_2  out  DATA_WIDTH each  to ALU operands
- alu_sel  out  SEL_WIDTH  to ALU sel_ip
- alu_parity  out  1  to ALU parity_ip
- alu_ack  in  1  from ALU ready_op (input-accept pulse)
- alu_rvalid  in  1  from ALU valid_op
- alu_rdata  in  2*DATA_WIDTH  from ALU data_op
- alu_err  in  1  from ALU err_op
- alu_rready  out  1  to ALU ready_ip
- res_valid  out  1  result valid downstream
- res_ready  in  1  downstream accept
- res_data  out  2*DATA_WIDTH  captured result
- res_err  out  1  captured ALU parity error
- res_timeout  out  1  transaction aborted by timeout
- txn_cnt  out  16  completed transactions
- err_cnt  out  16  results with res_err or res_timeout

Function
REQ-005 SHALL implement FSM IDLE -> SEND -> WAIT_RES -> DELIVER -> IDLE; one transaction in flight.
REQ-006 IDLE: cmd_ready=1; on cmd_valid, register operands, sel, parity; go SEND next cycle.
REQ-007 alu_parity SHALL equal XOR-reduce of {cmd_a, cmd_b, cmd_sel} (even parity), inverted when cmd_bad_par=1.
REQ-008 SEND: alu_valid=1 with registered fields stable; on alu_ack=1 deassert alu_valid next cycle, go WAIT_RES.
REQ-009 WAIT_RES: on alu_rvalid=1 capture alu_rdata/alu_err, assert alu_rready for exactly one cycle, go DELIVER.
REQ-010 alu_rready SHALL be 0 in all other cycles; alu_valid SHALL be 0 outside SEND.
REQ-011 DELIVER: res_valid=1, res_data/res_err/res_timeout stable until res_ready=1; then IDLE.
REQ-012 Phase counter SHALL reset on entry to SEND and WAIT_RES; if it reaches TIMEOUT in either, go DELIVER with res_timeout=1, res_data=0, res_err=0, alu_valid/alu_rready=0.
REQ-013 alu_ack or alu_rvalid arriving in the same cycle as timeout expiry SHALL take precedence over timeout.
REQ-014 alu_ack outside SEND and alu_rvalid outside WAIT_RES SHALL be ignored.
REQ-015 txn_cnt SHALL increment on each DELIVER handshake, wrapping at 2^16; err_cnt SHALL increment on handshakes with res_err|res_timeout, saturating at 0xFFFF.
REQ-016 cmd_ready SHALL be 0 outside IDLE; back-to-back commands: minimum 1 idle cycle between transactions.

Reset
REQ-017 rst=0 SHALL immediately force IDLE and all outputs to 0 except cmd_ready=1; counters cleared; registered data 0.
REQ-018 Reset mid-transaction SHALL abandon it without counting; release synchronous to clk.

Verification
REQ-019 a=0x0003,b=0x0005,sel=0, ALU returns 0x00000008 err=0 -> res_data=0x00000008, res_err=0, txn_cnt=1, err_cnt=0.
REQ-020 cmd_bad_par=1, a=0x0001,b=0x0000,sel=0 -> alu_parity=0, ALU err=1 -> res_err=1, err_cnt=1.
REQ-021 alu_ack never asserted -> alu_valid held 64 cycles, then res_valid=1, res_timeout=1, res_data=0.
REQ-022 res_ready held 0 for 10 cycles in DELIVER -> res_valid/res_data stable, cmd_ready=0, alu_rready=0 throughout.
REQ-023 rst=0 during WAIT_RES -> outputs cleared same cycle, txn_cnt=0, next command completes normally.
REQ-024 alu_rvalid in cycle of timeout expiry -> result captured, res_timeout=0.
